// File: rtl/shift_cmd_seq.sv
// Command sequencer feeding the 8-bit shifter: buffers commands in a FIFO and replays each op for rpt+1 cycles.
// Optional SHIFT_CMD_CNT_EN adds cmd_cnt, an 8-bit wrapping count of completed commands.
module shift_cmd_seq #(
  parameter int DEPTH = 4,
  parameter int REP_W = 3
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [2:0]               cmd_op,
  input  logic [1:0]               cmd_shamt,
  input  logic [7:0]               cmd_data,
  input  logic [REP_W-1:0]         cmd_rpt,
  output logic [2:0]               op,
  output logic [1:0]               shamt,
  output logic [7:0]               d_in,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH):0]   fifo_cnt
`ifdef SHIFT_CMD_CNT_EN
  ,
  output logic [7:0]               cmd_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t           state_q, state_d;
  logic [REP_W-1:0] rem_q, rem_d;
  logic [2:0]       op_q, op_d;
  logic [1:0]       shamt_q, shamt_d;
  logic [7:0]       d_in_q, d_in_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [2:0]       fifo_op_q    [DEPTH];
  logic [1:0]       fifo_shamt_q [DEPTH];
  logic [7:0]       fifo_data_q  [DEPTH];
  logic [REP_W-1:0] fifo_rpt_q   [DEPTH];

  logic             push;
  logic             pop;
  logic [2:0]       push_op;

  assign cmd_ready = (cnt_q != CW'(DEPTH));
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (cnt_q != '0) && ((state_q == IDLE) || (rem_q == '0));
  assign push_op   = (cmd_op > 3'd4) ? 3'd0 : cmd_op;

  assign op       = op_q;
  assign shamt    = shamt_q;
  assign d_in     = d_in_q;
  assign fifo_cnt = cnt_q;
  assign busy     = (state_q == ISSUE) || (cnt_q != '0);
  assign done     = (state_q == ISSUE) && (rem_q == '0);

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    op_d     = op_q;
    shamt_d  = shamt_q;
    d_in_d   = d_in_q;
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase

    // A pop always loads the head, so the next command follows the last issue cycle with no bubble.
    if (pop) begin
      state_d = ISSUE;
      op_d    = fifo_op_q[rd_ptr_q];
      shamt_d = fifo_shamt_q[rd_ptr_q];
      d_in_d  = fifo_data_q[rd_ptr_q];
      rem_d   = fifo_rpt_q[rd_ptr_q];
    end else if (state_q == ISSUE) begin
      if (rem_q != '0) begin
        rem_d = rem_q - REP_W'(1);
      end else begin
        op_d    = 3'd0;
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      rem_q    <= '0;
      op_q     <= 3'd0;
      shamt_q  <= 2'd0;
      d_in_q   <= 8'd0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      op_q     <= op_d;
      shamt_q  <= shamt_d;
      d_in_q   <= d_in_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_op_q[wr_ptr_q]    <= push_op;
      fifo_shamt_q[wr_ptr_q] <= cmd_shamt;
      fifo_data_q[wr_ptr_q]  <= cmd_data;
      fifo_rpt_q[wr_ptr_q]   <= cmd_rpt;
    end
  end

`ifdef SHIFT_CMD_CNT_EN
  logic [7:0] cmd_cnt_q, cmd_cnt_d;

  assign cmd_cnt = cmd_cnt_q;

  always_comb begin
    cmd_cnt_d = done ? cmd_cnt_q + 8'd1 : cmd_cnt_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd_cnt_q <= 8'd0;
    end else begin
      cmd_cnt_q <= cmd_cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_shift_cmd_seq.sv
// Scoreboard bench for shift_cmd_seq: a timeline model predicts, per accepted command,
// the exact cycles it occupies on the shifter outputs; a monitor pops and compares each cycle.
module tb_shift_cmd_seq;

   localparam int DEPTH = 4;
   localparam int REP_W = 3;

   logic             clk = 1'b0;
   logic             reset_n = 1'b0;
   logic             cmd_valid = 1'b0;
   logic             cmd_ready;
   logic [2:0]       cmd_op = 3'd0;
   logic [1:0]       cmd_shamt = 2'd0;
   logic [7:0]       cmd_data = 8'd0;
   logic [REP_W-1:0] cmd_rpt = '0;
   logic [2:0]       op;
   logic [1:0]       shamt;
   logic [7:0]       d_in;
   logic             busy;
   logic             done;
   logic [$clog2(DEPTH):0] fifo_cnt;
`ifdef SHIFT_CMD_CNT_EN
   logic [7:0]       cmd_cnt;
`endif

   shift_cmd_seq #(.DEPTH(DEPTH), .REP_W(REP_W)) dut (
      .clk(clk),
      .reset_n(reset_n),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_op(cmd_op),
      .cmd_shamt(cmd_shamt),
      .cmd_data(cmd_data),
      .cmd_rpt(cmd_rpt),
      .op(op),
      .shamt(shamt),
      .d_in(d_in),
      .busy(busy),
      .done(done),
      .fifo_cnt(fifo_cnt)
`ifdef SHIFT_CMD_CNT_EN
      ,
      .cmd_cnt(cmd_cnt)
`endif
   );

   // Free-running clock and an edge counter; "cycle e" is the interval after rising edge e.
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int compared = 0;
   int mismatched = 0;

   // One entry per cycle that a command is presented to the shifter.
   typedef struct {
      int         cyc;
      logic [2:0] op;
      logic [1:0] sh;
      logic [7:0] d;
      logic       dn;
   } exp_t;

   exp_t       expq[$];
   int         pendq[$];
   int         lastEnd = -1;
   logic [1:0] lastSh = 2'd0;
   logic [7:0] lastD = 8'd0;
   int         doneCnt = 0;
   bit         monEn = 1'b0;

   task automatic checkOutput(input string name, input int act, input int exp);
      compared++;
      if (act != exp) begin
         mismatched++;
         $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   // Drive one cycle of stimulus. The model decides acceptance from its own occupancy:
   // a command waits in the FIFO from its push edge until the edge where it starts issuing.
   task automatic applyStimulus(input bit v, input logic [2:0] o, input logic [1:0] s,
                                input logic [7:0] d, input logic [REP_W-1:0] r);
      int e;
      int st;
      bit rdy;
      exp_t x;
      @(negedge clk);
      #1;
      e = cyc;
      while (pendq.size() > 0 && pendq[0] <= e) void'(pendq.pop_front());
      rdy = (pendq.size() != DEPTH);
      checkOutput("fifo_cnt", int'(fifo_cnt), pendq.size());
      checkOutput("cmd_ready", int'(cmd_ready), int'(rdy));
      checkOutput("busy", int'(busy), int'(pendq.size() > 0 || e <= lastEnd));
      cmd_valid = v;
      cmd_op    = o;
      cmd_shamt = s;
      cmd_data  = d;
      cmd_rpt   = r;
      if (v && rdy) begin
         st = (e + 2 > lastEnd + 1) ? e + 2 : lastEnd + 1;
         pendq.push_back(st);
         for (int i = 0; i <= int'(r); i++) begin
            x.cyc = st + i;
            x.op  = (o > 3'd4) ? 3'd0 : o;
            x.sh  = s;
            x.d   = d;
            x.dn  = (i == int'(r));
            expq.push_back(x);
         end
         lastEnd = st + int'(r);
      end
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 3'd0, 2'd0, 8'd0, '0);
   endtask

   task automatic drain();
      for (int i = 0; i < 200 && cyc <= lastEnd + 1; i++) idleCycles(1);
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_op"}, int'(op), 0);
      checkOutput({tag, "_shamt"}, int'(shamt), 0);
      checkOutput({tag, "_d_in"}, int'(d_in), 0);
      checkOutput({tag, "_fifo_cnt"}, int'(fifo_cnt), 0);
      checkOutput({tag, "_cmd_ready"}, int'(cmd_ready), 1);
      checkOutput({tag, "_busy"}, int'(busy), 0);
      checkOutput({tag, "_done"}, int'(done), 0);
`ifdef SHIFT_CMD_CNT_EN
      checkOutput({tag, "_cmd_cnt"}, int'(cmd_cnt), 0);
`endif
   endtask

   // Asynchronous reset dropped mid-cycle; outputs must clear before any clock edge.
   task automatic doReset();
      @(negedge clk);
      #1;
      reset_n   = 1'b0;
      cmd_valid = 1'b0;
      #1;
      checkResetValues("midreset");
      expq.delete();
      pendq.delete();
      lastEnd = -1;
      lastSh  = 2'd0;
      lastD   = 8'd0;
      doneCnt = 0;
      #4;
      reset_n = 1'b1;
   endtask

   // Monitor: every cycle either the head entry is due and is compared, or the shifter sees NOP.
   initial begin
      int   e;
      exp_t x;
      forever begin
         @(negedge clk);
         if (monEn && reset_n) begin
            e = cyc;
`ifdef SHIFT_CMD_CNT_EN
            checkOutput("cmd_cnt", int'(cmd_cnt), doneCnt % 256);
`endif
            if (expq.size() > 0 && expq[0].cyc < e) begin
               checkOutput("stale_entry", e, expq[0].cyc);
               void'(expq.pop_front());
            end
            if (expq.size() > 0 && expq[0].cyc == e) begin
               x = expq.pop_front();
               lastSh = x.sh;
               lastD  = x.d;
               checkOutput("op", int'(op), int'(x.op));
               checkOutput("done", int'(done), int'(x.dn));
               if (x.dn) doneCnt++;
            end else begin
               checkOutput("op_nop", int'(op), 0);
               checkOutput("done_idle", int'(done), 0);
            end
            checkOutput("shamt", int'(shamt), int'(lastSh));
            checkOutput("d_in", int'(d_in), int'(lastD));
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not complete, cycle %0d", cyc);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      #12;
      checkResetValues("reset");
      #1;
      reset_n = 1'b1;
      monEn   = 1'b1;

      // Single LOAD with no repeat
      applyStimulus(1'b1, 3'b001, 2'b00, 8'h34, 3'd0);
      idleCycles(1);
      drain();

      // Back-to-back LSL (rpt 1) then LSR (rpt 0)
      applyStimulus(1'b1, 3'b010, 2'b01, 8'h11, 3'd1);
      applyStimulus(1'b1, 3'b011, 2'b01, 8'h22, 3'd0);
      idleCycles(1);
      drain();

      // Fill the FIFO behind a long ASR, then keep offering while full
      applyStimulus(1'b1, 3'b100, 2'b11, 8'hA5, 3'd7);
      applyStimulus(1'b1, 3'b001, 2'b00, 8'h01, 3'd0);
      applyStimulus(1'b1, 3'b010, 2'b01, 8'h02, 3'd1);
      applyStimulus(1'b1, 3'b011, 2'b10, 8'h03, 3'd2);
      applyStimulus(1'b1, 3'b100, 2'b11, 8'h04, 3'd0);
      for (int i = 0; i < 12; i++) applyStimulus(1'b1, 3'b001, 2'b01, 8'hC0 + 8'(i), 3'd0);
      idleCycles(1);
      drain();

      // Illegal opcode is issued as NOP but still carries shamt/data
      applyStimulus(1'b1, 3'b110, 2'b10, 8'h98, 3'd2);
      idleCycles(1);
      drain();

      // Randomised traffic
      for (int i = 0; i < 300; i++) begin
         applyStimulus(($urandom_range(0, 9) < 6), 3'($urandom_range(0, 7)),
                       2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)),
                       REP_W'($urandom_range(0, 7)));
      end
      idleCycles(1);
      drain();

      // Reset while an rpt=5 command has 3 repeats left and two more are queued
      applyStimulus(1'b1, 3'b010, 2'b01, 8'h5A, 3'd5);
      applyStimulus(1'b1, 3'b011, 2'b10, 8'h6B, 3'd1);
      applyStimulus(1'b1, 3'b001, 2'b11, 8'h7C, 3'd0);
      idleCycles(1);
      doReset();
      idleCycles(3);

      // Traffic after reset
      for (int i = 0; i < 100; i++) begin
         applyStimulus(($urandom_range(0, 9) < 7), 3'($urandom_range(0, 7)),
                       2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)),
                       REP_W'($urandom_range(0, 7)));
      end
      idleCycles(1);
      drain();
      idleCycles(2);

      checkOutput("expq_left", expq.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/shift_cmd_seq.md
Name: shift_cmd_seq

Overview:
- Command sequencer directly upstream of the 8-bit shifter stage. It drives the shifter's op, shamt and d_in inputs.
- Accepts shift commands over a valid/ready handshake and buffers them in a small FIFO.
- Replays each command's op for a programmable number of consecutive cycles, then returns the shifter to NOP when no work remains.

Parameters:
- DEPTH, 4, command FIFO entries (power of 2, >= 2)
- REP_W, 3, width of the per-command repeat field

Ports:
- clk  input  1  system clock, rising-edge
- reset_n  input  1  asynchronous active-low reset
- cmd_valid  input  1  command offered this cycle
- cmd_ready  output  1  FIFO can accept a command
- cmd_op  input  3  shifter opcode: 000 NOP, 001 LOAD, 010 LSL, 011 LSR, 100 ASR
- cmd_shamt  input  2  shift amount forwarded to shifter
- cmd_data  input  8  load data forwarded to shifter d_in
- cmd_rpt  input  REP_W  extra repeat count; the command is issued cmd_rpt+1 cycles
- op  output  3  registered opcode to shifter
- shamt  output  2  registered shift amount to shifter
- d_in  output  8  registered data to shifter
- busy  output  1  state==ISSUE or FIFO non-empty
- done  output  1  high during the last issue cycle of each command
- fifo_cnt  output  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Clocking and reset:
  - Single clock.
  - Reset is asynchronous, active-low, on reset_n.
  - During reset: op=000, shamt=00, d_in=00h, FIFO empty, fifo_cnt=0, cmd_ready=1, busy=0, done=0, state=IDLE, repeat counter=0.
  - Reset asserted mid-command aborts it immediately and discards all queued commands.
- FIFO:
  - cmd_ready = (fifo_cnt != DEPTH), decoded from the count only.
  - When full, cmd_ready stays 0 even if a pop occurs that same cycle. There is no pass-through path.
  - Push when cmd_valid && cmd_ready; {op, shamt, data, rpt} is stored at the tail.
  - Opcodes 101-111 are stored as 000. They are then issued as NOP for rpt+1 cycles.
  - Pointers wrap modulo DEPTH.
  - A simultaneous push and pop leaves fifo_cnt unchanged.
- State machine:
  - Two states, IDLE and ISSUE. A down-counter rem of width REP_W tracks remaining repeats.
  - IDLE:
    - Outputs op=000; shamt and d_in hold their last values.
    - If fifo_cnt != 0: pop the head, register op/shamt/d_in from it, set rem=rpt, go to ISSUE.
  - ISSUE, rem != 0: rem decrements; outputs hold.
  - ISSUE, rem == 0 (done=1 this cycle):
    - If the FIFO is non-empty, pop the next command on this edge. It is issued back-to-back with no NOP bubble, and the state stays ISSUE.
    - If the FIFO is empty, op<=000 and the state goes to IDLE.
- Latency:
  - A command pushed at edge k into an empty FIFO while IDLE is popped at edge k+1.
  - Its op is visible on the outputs from k+1 through k+1+rpt.
  - The first NOP appears after edge k+2+rpt.
- Output rules:
  - d_in and shamt update on every pop, whatever the opcode.
  - The shifter ignores d_in for shift ops, so no masking is applied.
  - done is decoded from registered state (ISSUE && rem==0), so it is glitch-free.
- Boundary conditions:
  - A push into an empty FIFO in the same cycle the sequencer is IDLE is not popped until the following edge.
  - rpt = 2^REP_W-1 gives the maximum run of 2^REP_W cycles.

Optional Feature:
- Macro: SHIFT_CMD_CNT_EN.
- Defined:
  - Adds output port cmd_cnt[7:0], reset to 00h.
  - Increments on every cycle with done=1; wraps FFh->00h.
  - Illegal opcodes converted to NOP are still counted.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset values: hold reset_n=0 for 13 ns with clk toggling -> op=000, d_in=00h, cmd_ready=1, busy=0, fifo_cnt=0.
- Single command: push {LOAD, 00, 34h, rpt=0} -> op=001 with d_in=34h for exactly 1 cycle, done=1 that cycle, then op=000 and busy=0.
- Back-to-back commands: push {LSL,01,rpt=1} then {LSR,01,rpt=0} on consecutive cycles -> op shows 010,010,011 with no 000 gap; done pulses on the 2nd and 3rd of those cycles.
- Full FIFO: stall issue with a long command {ASR,11,rpt=7}, push 4 more -> fifo_cnt=4, cmd_ready=0; a push attempted while full is not stored, including the cycle of a pop; all 4 later drain in order.
- Illegal opcode: push {110,10,98h,rpt=2} -> op=000 for 3 cycles, done on the 3rd, shamt=10, d_in=98h.
- Mid-command reset: drop reset_n during rem=3 of an rpt=5 command with 2 queued -> outputs return to reset values asynchronously, fifo_cnt=0, and with SHIFT_CMD_CNT_EN, cmd_cnt=00h.
